swo_itm_tx: RTL and testbench

Target-side SWO transmitter: packs ITM stimulus-port writes into ITM software-source packets and serializes them onto a single SWO line, either as UART (NRZ) or as Manchester when compiled in. It is the sending end of the SWO capture path. Its output drives the capture side's `swo` input in loopback self-test builds and in simulation benches, so the trace front-end can be exercised without a real target.

---
 rtl/swo_tx_pkg.sv | 51 +++++
 rtl/swo_bit_timer.sv | 34 +++
 rtl/swo_itm_tx.sv | 210 +++++++++++++++++++++
 tb/tb_swo_itm_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/swo_tx_pkg.sv
// Shared types and constants for the SWO ITM transmitter.
// The packet FSM, ITM header layout, size coding and line idle levels live here.
package swo_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_TAIL    = 3'd3,
    ST_ERR     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10,
    SZ_WORD = 2'b11
  } size_t;

  // ITM software-source header: {port[4:0], 1'b0, size[1:0]}
  localparam int unsigned HDR_SIZE_LSB = 0;
  localparam int unsigned HDR_ZERO_BIT = 2;
  localparam int unsigned HDR_PORT_LSB = 3;

  localparam logic UART_IDLE  = 1'b1;
  localparam logic UART_START = 1'b0;
  localparam logic UART_STOP  = 1'b1;
  localparam logic MAN_IDLE   = 1'b0;
  localparam logic MAN_START  = 1'b1;

  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] make_header(input logic [4:0] port, input logic [1:0] size);
    logic [7:0] h;
    h = '0;
    h[HDR_PORT_LSB +: 5] = port;
    h[HDR_ZERO_BIT]      = 1'b0;
    h[HDR_SIZE_LSB +: 2] = size;
    return h;
  endfunction

endpackage

// File: rtl/swo_bit_timer.sv
// Reloadable bit-period timer: one-cycle strobe every D+1 cycles.
// The divider is captured on load so later divider changes do not disturb a packet.
module swo_bit_timer #(
  parameter int unsigned pDIV_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic                  i_en,
  input  logic [pDIV_WIDTH-1:0] i_div,
  output logic                  o_tick
);

  logic [pDIV_WIDTH-1:0] r_div;
  logic [pDIV_WIDTH-1:0] r_cnt;

  // Down-counter: restart from the new divider on load, reload from the held one on expiry
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_div <= i_div;
      r_cnt <= i_div;
    end else if (r_cnt == '0) begin
      r_cnt <= r_div;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/swo_itm_tx.sv
// SWO ITM transmitter: packs stimulus-port writes into ITM packets and
// serializes them as UART (NRZ) or, when SWO_MANCHESTER_EN is defined, Manchester.
module swo_itm_tx
  import swo_tx_pkg::*;
#(
  parameter int unsigned pDIV_WIDTH   = 16,
  parameter int unsigned pCOUNT_WIDTH = 16
) (
  input  logic                    fe_clk,
  input  logic                    reset_i,
  input  logic [pDIV_WIDTH-1:0]   I_baud_div,
  input  logic                    I_manchester,
  input  logic                    I_valid,
  output logic                    O_ready,
  input  logic [4:0]              I_port,
  input  logic [1:0]              I_size,
  input  logic [31:0]             I_data,
  output logic                    O_swo,
  output logic                    O_busy,
  output logic [pCOUNT_WIDTH-1:0] O_pkt_count,
  output logic                    O_error
);

  state_t                  r_state, w_state_nx;
  logic [7:0]              r_shift, w_shift_nx;
  logic [3:0]              r_bitpos, w_bitpos_nx;
  logic [2:0]              r_byte_idx, w_byte_idx_nx;
  logic [2:0]              r_nbytes;
  logic [31:0]             r_data;
  logic                    r_man;
  logic                    r_bit, w_bit_nx;
  logic                    r_half, w_half_nx;
  logic                    r_swo, w_swo_nx;
  logic                    r_error, w_error_nx;
  logic [pCOUNT_WIDTH-1:0] r_count, w_count_nx;

  logic       w_man_sel;
  logic       w_accept;
  logic       w_tick;
  logic       w_half_tick;
  logic       w_bit_end;
  logic       w_timer_en;
  logic [2:0] w_sel;
  logic [7:0] w_next_byte;
  logic       w_idle_lvl;

`ifdef SWO_MANCHESTER_EN
  assign w_man_sel   = I_manchester;
  assign w_half_tick = w_tick && r_man && !r_half;
`else
  logic w_unused_manchester;
  assign w_unused_manchester = I_manchester;
  assign w_man_sel   = 1'b0;
  assign w_half_tick = 1'b0;
`endif

  assign O_ready     = (r_state == ST_IDLE) && !reset_i;
  assign O_busy      = (r_state != ST_IDLE);
  assign O_swo       = r_swo;
  assign O_error     = r_error;
  assign O_pkt_count = r_count;

  assign w_accept   = I_valid && O_ready;
  assign w_idle_lvl = w_man_sel ? MAN_IDLE : UART_IDLE;
  assign w_timer_en = (r_state == ST_HDR) || (r_state == ST_PAYLOAD) || (r_state == ST_TAIL);
  assign w_bit_end  = w_tick && (!r_man || r_half);

  // Byte index counts down from N, so the payload byte to load next is N - index
  assign w_sel = r_nbytes - r_byte_idx;

  // Payload byte selector
  always_comb begin
    case (w_sel[1:0])
      2'd0:    w_next_byte = r_data[7:0];
      2'd1:    w_next_byte = r_data[15:8];
      2'd2:    w_next_byte = r_data[23:16];
      default: w_next_byte = r_data[31:24];
    endcase
  end

  swo_bit_timer #(
    .pDIV_WIDTH(pDIV_WIDTH)
  ) u_timer (
    .i_clk  (fe_clk),
    .i_rst  (reset_i),
    .i_load (w_accept),
    .i_en   (w_timer_en),
    .i_div  (I_baud_div),
    .o_tick (w_tick)
  );

  // Packet registers and captured write fields
  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bitpos   <= '0;
      r_byte_idx <= '0;
      r_nbytes   <= '0;
      r_data     <= '0;
      r_man      <= 1'b0;
      r_bit      <= 1'b0;
      r_half     <= 1'b0;
      r_swo      <= 1'b1;
      r_error    <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_shift    <= w_shift_nx;
      r_bitpos   <= w_bitpos_nx;
      r_byte_idx <= w_byte_idx_nx;
      r_bit      <= w_bit_nx;
      r_half     <= w_half_nx;
      r_swo      <= w_swo_nx;
      r_error    <= w_error_nx;
      r_count    <= w_count_nx;
      if (w_accept) begin
        r_nbytes <= size_to_bytes(I_size);
        r_data   <= I_data;
        r_man    <= w_man_sel;
      end
    end
  end

  // Next-state and line encoding.
  // Bit position 0 is the start bit, 1..8 the data bits, 9 the UART inter-byte stop bit;
  // Manchester bytes after the header start directly at position 1 (one start bit per frame).
  always_comb begin
    w_state_nx    = r_state;
    w_shift_nx    = r_shift;
    w_bitpos_nx   = r_bitpos;
    w_byte_idx_nx = r_byte_idx;
    w_bit_nx      = r_bit;
    w_half_nx     = r_half;
    w_swo_nx      = r_swo;
    w_error_nx    = 1'b0;
    w_count_nx    = r_count;
    case (r_state)
      ST_IDLE: begin
        w_swo_nx = w_idle_lvl;
        if (w_accept) begin
          if (I_size == SZ_NONE) begin
            w_state_nx = ST_ERR;
            w_error_nx = 1'b1;
          end else begin
            w_state_nx    = ST_HDR;
            w_shift_nx    = make_header(I_port, I_size);
            w_byte_idx_nx = size_to_bytes(I_size);
            w_bitpos_nx   = 4'd0;
            w_half_nx     = 1'b0;
            w_bit_nx      = w_man_sel ? MAN_START : UART_START;
            w_swo_nx      = w_bit_nx;
          end
        end
      end
      ST_ERR: begin
        w_state_nx = ST_IDLE;
      end
      ST_HDR, ST_PAYLOAD: begin
        if (w_half_tick) begin
          w_half_nx = 1'b1;
          w_swo_nx  = ~r_bit;
        end else if (w_bit_end) begin
          w_half_nx = 1'b0;
          if (r_bitpos == 4'd0) begin
            w_bitpos_nx = 4'd1;
            w_bit_nx    = r_shift[0];
          end else if (r_bitpos < 4'd8) begin
            w_shift_nx  = {1'b0, r_shift[7:1]};
            w_bitpos_nx = r_bitpos + 4'd1;
            w_bit_nx    = r_shift[1];
          end else if ((r_bitpos == 4'd8) && (r_byte_idx == 3'd0)) begin
            w_state_nx = ST_TAIL;
            w_bit_nx   = r_man ? MAN_IDLE : UART_STOP;
          end else if ((r_bitpos == 4'd8) && !r_man) begin
            w_bitpos_nx = 4'd9;
            w_bit_nx    = UART_STOP;
          end else begin
            w_state_nx    = ST_PAYLOAD;
            w_shift_nx    = w_next_byte;
            w_byte_idx_nx = r_byte_idx - 3'd1;
            if (r_man) begin
              w_bitpos_nx = 4'd1;
              w_bit_nx    = w_next_byte[0];
            end else begin
              w_bitpos_nx = 4'd0;
              w_bit_nx    = UART_START;
            end
          end
          w_swo_nx = w_bit_nx;
        end
      end
      ST_TAIL: begin
        // Both Manchester tail half-bits stay low; the UART tail is the last stop bit
        if (w_half_tick) begin
          w_half_nx = 1'b1;
        end else if (w_bit_end) begin
          w_half_nx  = 1'b0;
          w_state_nx = ST_IDLE;
          w_count_nx = r_count + 1'b1;
          w_swo_nx   = w_idle_lvl;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_swo_itm_tx.sv
// Self-checking bench for swo_itm_tx: expected line waveforms are built per packet
// from the framing rules, then compared cycle by cycle.
module tb_swo_itm_tx;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

`ifdef SWO_MANCHESTER_EN
  localparam bit MAN_BUILT = 1'b1;
`else
  localparam bit MAN_BUILT = 1'b0;
`endif

  logic          fe_clk = 1'b0;
  logic          reset_i;
  logic [DW-1:0] I_baud_div;
  logic          I_manchester;
  logic          I_valid;
  logic          O_ready;
  logic [4:0]    I_port;
  logic [1:0]    I_size;
  logic [31:0]   I_data;
  logic          O_swo;
  logic          O_busy;
  logic [CW-1:0] O_pkt_count;
  logic          O_error;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned exp_cnt = 0;
  logic        exp_q[$];

  logic [4:0]  nx_port;
  logic [1:0]  nx_size;
  logic [31:0] nx_data;
  logic [15:0] nx_div;

  swo_itm_tx #(
    .pDIV_WIDTH  (DW),
    .pCOUNT_WIDTH(CW)
  ) dut (
    .fe_clk      (fe_clk),
    .reset_i     (reset_i),
    .I_baud_div  (I_baud_div),
    .I_manchester(I_manchester),
    .I_valid     (I_valid),
    .O_ready     (O_ready),
    .I_port      (I_port),
    .I_size      (I_size),
    .I_data      (I_data),
    .O_swo       (O_swo),
    .O_busy      (O_busy),
    .O_pkt_count (O_pkt_count),
    .O_error     (O_error)
  );

  always #5 fe_clk = ~fe_clk;

  task automatic tick();
    @(posedge fe_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void push_rep(input logic v, input int unsigned dv);
    for (int unsigned r = 0; r <= dv; r++) exp_q.push_back(v);
  endfunction

  // Expected line level for every cycle of one packet
  function automatic void build_expect(input logic [4:0] p, input logic [1:0] s,
                                       input logic [31:0] d, input int unsigned dv,
                                       input bit m);
    int unsigned nb;
    int unsigned bytes[$];
    logic        bv;
    exp_q.delete();
    nb = (s == 2'd3) ? 4 : int'(s);
    bytes.push_back(int'(p) * 8 + int'(s));
    for (int unsigned i = 0; i < nb; i++) bytes.push_back((d >> (8 * i)) & 32'hFF);
    if (m) begin
      push_rep(1'b1, dv);
      push_rep(1'b0, dv);
      foreach (bytes[k]) begin
        for (int unsigned b = 0; b < 8; b++) begin
          bv = ((bytes[k] >> b) & 1) != 0;
          push_rep(bv, dv);
          push_rep(!bv, dv);
        end
      end
      push_rep(1'b0, dv);
      push_rep(1'b0, dv);
    end else begin
      foreach (bytes[k]) begin
        push_rep(1'b0, dv);
        for (int unsigned b = 0; b < 8; b++) push_rep(((bytes[k] >> b) & 1) != 0, dv);
        push_rep(1'b1, dv);
      end
    end
  endfunction

  // Offer one write and check the whole packet; reset_at > 0 aborts it at that cycle,
  // hold_next presents the nx_* write mid-packet and leaves it pending.
  task automatic send(input logic [4:0] p, input logic [1:0] s, input logic [31:0] d,
                      input logic [15:0] dv, input bit m, input int unsigned reset_at,
                      input bit hold_next);
    bit   em;
    logic idle;
    em   = m && MAN_BUILT;
    idle = em ? 1'b0 : 1'b1;
    I_manchester = m;
    I_baud_div   = dv;
    I_port       = p;
    I_size       = s;
    I_data       = d;
    I_valid      = 1'b1;
    for (int k = 0; k < 5000 && O_ready !== 1'b1; k++) tick();
    chk("ready_wait", {31'd0, O_ready}, 32'd1);
    tick();
    I_valid    = 1'b0;
    I_port     = 5'($urandom);
    I_size     = 2'($urandom);
    I_data     = $urandom;
    I_baud_div = 16'($urandom_range(0, 7));
    if (s == 2'd0) begin
      chk("err_pulse", {29'd0, O_error, O_ready, O_swo}, {29'd0, 1'b1, 1'b0, idle});
      tick();
      chk("err_after", {29'd0, O_error, O_ready, O_swo}, {29'd0, 1'b0, 1'b1, idle});
      chk("err_count", 32'(O_pkt_count), exp_cnt);
      return;
    end
    build_expect(p, s, d, int'(dv), em);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (reset_at != 0 && i == int'(reset_at)) begin
        reset_i = 1'b1;
        tick();
        exp_cnt = 0;
        chk("abort_line", {29'd0, O_swo, O_busy, O_ready}, {29'd0, 1'b1, 1'b0, 1'b0});
        chk("abort_count", 32'(O_pkt_count), exp_cnt);
        reset_i = 1'b0;
        tick();
        return;
      end
      chk($sformatf("line[%0d]", i), {28'd0, O_swo, O_busy, O_ready, O_error},
          {28'd0, exp_q[i], 1'b1, 1'b0, 1'b0});
      if (hold_next && i == 5) begin
        I_valid    = 1'b1;
        I_port     = nx_port;
        I_size     = nx_size;
        I_data     = nx_data;
        I_baud_div = nx_div;
      end
      tick();
    end
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    chk("end_state", {29'd0, O_swo, O_busy, O_ready}, {29'd0, idle, 1'b0, 1'b1});
    chk("pkt_count", 32'(O_pkt_count), exp_cnt);
  endtask

  initial begin
    reset_i      = 1'b1;
    I_baud_div   = '0;
    I_manchester = 1'b0;
    I_valid      = 1'b0;
    I_port       = '0;
    I_size       = '0;
    I_data       = '0;
    tick();
    tick();
    tick();
    chk("reset_outs", {28'd0, O_swo, O_busy, O_ready, O_error}, 32'b1000);
    chk("reset_count", 32'(O_pkt_count), 32'd0);
    reset_i = 1'b0;
    tick();

    // Abort in the 3rd payload byte of a 4-byte packet, then a clean packet
    send(5'd5, 2'd3, $urandom, 16'd1, 1'b0, (30 + 3) * 2, 1'b0);
    send(5'd9, 2'd2, $urandom, 16'd2, 1'b0, 0, 1'b0);

    // Directed UART packets
    send(5'd1, 2'd1, 32'h0000_00A5, 16'd3, 1'b0, 0, 1'b0);
    nx_port = 5'($urandom);
    nx_size = 2'($urandom_range(1, 3));
    nx_data = $urandom;
    nx_div  = 16'($urandom_range(0, 2));
    send(5'd31, 2'd3, 32'h1234_5678, 16'd0, 1'b0, 0, 1'b1);
    send(nx_port, nx_size, nx_data, nx_div, 1'b0, 0, 1'b0);

    // Invalid size
    send(5'($urandom), 2'd0, $urandom, 16'd2, 1'b0, 0, 1'b0);

`ifdef SWO_MANCHESTER_EN
    I_manchester = 1'b1;
    tick();
    chk("man_idle", {31'd0, O_swo}, 32'd0);
    send(5'd0, 2'd1, 32'h0000_0001, 16'd1, 1'b1, 0, 1'b0);
    send(5'($urandom), 2'd3, $urandom, 16'd0, 1'b1, 0, 1'b0);
    send(5'($urandom), 2'd0, $urandom, 16'd1, 1'b1, 0, 1'b0);
    I_manchester = 1'b0;
    tick();
    chk("uart_idle", {31'd0, O_swo}, 32'd1);
`endif

    // Random packets; in a UART-only build I_manchester must have no effect
    for (int n = 0; n < 10; n++) begin
      send(5'($urandom), 2'($urandom_range(1, 3)), $urandom,
           16'($urandom_range(0, 3)), 1'($urandom), 0, 1'b0);
    end

    // Run the counter through its wrap with short packets
    I_manchester = 1'b0;
    for (int n = 0; n < 18; n++) begin
      send(5'($urandom), 2'd1, $urandom, 16'd0, 1'b0, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
